incomp_if1: RTL and testbench
=============================

Name: incomp_if1

Overview:
- Clocked model of the classic incomplete-if construct: when select `i0` is high, output `y` takes data `i1`; when `i0` is low, `y` holds its last value.
- Used in the inferred-latch study set as the synthesizable, flop-based equivalent of the latch a combinational incomplete if would infer.
- Adds load/hold status outputs so benches can observe hold behaviour.

Parameters:
- WIDTH, 1, bit width of data inputs i1, i2 and output y.
- CNT_W, 8, width of the saturating hold-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- i0  input  1  select/enable; high = load i1, low = hold.
- i1  input  WIDTH  primary data loaded when i0=1.
- i2  input  WIDTH  alternate data; ignored unless COMPLETE_ELSE_EN is defined.
- y  output  WIDTH  registered output.
- loaded  output  1  high once y has been written by a load since reset.
- hold_cnt  output  CNT_W  consecutive cycles y has held, saturating.

Behaviour:
- Everything is sampled on the rising edge of clk; no combinational path from inputs to outputs.
- Reset: rst_n=0 at a clock edge gives y=0, loaded=0, hold_cnt=0. Reset overrides all inputs. Asserting reset mid-sequence clears state on that same edge.
- Load: when rst_n=1 and i0=1, on the edge:
  - y <= i1
  - loaded <= 1
  - hold_cnt <= 0
- Hold: when rst_n=1 and i0=0, on the edge:
  - y is unchanged
  - loaded is unchanged
  - hold_cnt <= hold_cnt+1, saturating at all-ones (2^CNT_W-1); it never wraps.
- Latency: one cycle from the i0/i1 sample to y.
- After reset and before the first load, y holds 0 and loaded=0. This is the hold-of-reset-value case.
- Changes on i1 while i0=0 have no effect on y. Changes on i2 never affect y in the base build.
- Sampling is level-based only: i0 toggling on consecutive cycles loads on every cycle where i0=1 at the edge.
- Outputs are always driven; X on i0 is not propagated into hold_cnt arithmetic beyond normal simulation semantics.

Optional Feature:
- Macro COMPLETE_ELSE_EN.
- When defined, the if is completed: i0=0 loads y <= i2, so no hold occurs on y.
  - loaded is set by any non-reset edge.
  - hold_cnt stays 0 permanently.
- When undefined, the base hold behaviour above applies and i2 is unused (lint waiver permitted).

Decomposition:
- Shared package incomp_if1_pkg:
  - default WIDTH and CNT_W constants
  - a function computing the saturating increment for CNT_W-bit values
- One natural sub-module: incomp_if1_sat_cnt, the saturating hold counter with clear and increment inputs.
- The data register and loaded flag stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with i0=1, i1=1 -> y=0, loaded=0, hold_cnt=0 on every edge while rst_n=0.
- Load then hold (WIDTH=1): i0=1, i1=1 for one edge, then i0=0 with i1 toggling every cycle for 5 edges -> y=1 throughout, loaded=1, hold_cnt steps 1..5.
- Pre-load hold: after reset, i0=0 for 3 edges, i1=1 -> y=0, loaded=0, hold_cnt=3.
- Saturation (CNT_W=3): i0=0 for 10 edges after one load -> hold_cnt reaches 7 and stays 7; next i0=1 edge clears it to 0.
- Free-running toggles: i0 period 634 ns, i1 period 74 ns, i2 period 114 ns for 3000 ns -> at each edge, y equals i1 sampled at the last edge with i0=1, else its previous value; i2 never observed on y.
- COMPLETE_ELSE_EN build: i0=0, i2=1, i1=0 -> y=1 one cycle later, hold_cnt=0; i0=1, i1=0 -> y=0.

Source files
------------

// File: rtl/incomp_if1_pkg.sv
// Shared constants and the saturating-increment helper for incomp_if1.
// Optional feature macro used by the top: COMPLETE_ELSE_EN.
package incomp_if1_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  // Counter values are carried in 32 bits so one function serves any CNT_W <= 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned cnt_w);
    logic [31:0] max_val;
    max_val = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/incomp_if1_sat_cnt.sv
// Saturating hold-cycle counter: reset and clear force zero, increment stops at all-ones.
module incomp_if1_sat_cnt
  import incomp_if1_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), CNT_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/incomp_if1.sv
// Flop-based model of an incomplete if: i0=1 loads i1 into y, i0=0 holds y.
// Define COMPLETE_ELSE_EN to complete the if (i0=0 loads i2, never holds).
module incomp_if1
  import incomp_if1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] y,
  output logic             loaded,
  output logic [CNT_W-1:0] hold_cnt
);

  logic [WIDTH-1:0] r_y;
  logic             r_loaded;
  logic             w_clr;
  logic             w_inc;

`ifdef COMPLETE_ELSE_EN
  // Every non-reset edge writes y, so there is never a hold to count.
  assign w_clr = 1'b1;
  assign w_inc = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y      <= '0;
      r_loaded <= 1'b0;
    end else begin
      r_y      <= i0 ? i1 : i2;
      r_loaded <= 1'b1;
    end
  end
`else
  logic w_unused_i2;
  assign w_unused_i2 = ^i2;

  assign w_clr = i0;
  assign w_inc = ~i0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y      <= '0;
      r_loaded <= 1'b0;
    end else if (i0) begin
      r_y      <= i1;
      r_loaded <= 1'b1;
    end
  end
`endif

  incomp_if1_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_cnt (hold_cnt)
  );

  assign y      = r_y;
  assign loaded = r_loaded;

endmodule

// File: tb/tb_incomp_if1.sv
// Directed and free-running checks of incomp_if1 against a scoreboard of expected states.
module tb_incomp_if1;

  localparam int WIDTH = 1;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             loaded;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] y;
  logic             loaded;
  logic [CNT_W-1:0] hold_cnt;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Reference state of the behavioural model
  logic [WIDTH-1:0] m_y;
  logic             m_loaded;
  logic [CNT_W-1:0] m_cnt;

  incomp_if1 #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i0       (i0),
    .i1       (i1),
    .i2       (i2),
    .y        (y),
    .loaded   (loaded),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic rn, input logic a0, input logic [WIDTH-1:0] a1,
                            input logic [WIDTH-1:0] a2);
    if (!rn) begin
      m_y = '0; m_loaded = 1'b0; m_cnt = '0;
    end else if (a0) begin
      m_y = a1; m_loaded = 1'b1; m_cnt = '0;
    end else begin
`ifdef COMPLETE_ELSE_EN
      m_y = a2; m_loaded = 1'b1; m_cnt = '0;
`else
      if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
`endif
    end
  endtask

  task automatic step(input logic rn, input logic a0, input logic [WIDTH-1:0] a1,
                      input logic [WIDTH-1:0] a2, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n = rn; i0 = a0; i1 = a1; i2 = a2;
    model_edge(rn, a0, a1, a2);
    e.y = m_y; e.loaded = m_loaded; e.cnt = m_cnt; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s scoreboard: observed empty queue, expected one entry", tag);
    end else begin
      got = exp_q.pop_front();
      vectors++;
      assert (y === got.y) else begin
        miscompares++;
        $error("FAIL %s y: observed %0h expected %0h", got.tag, y, got.y);
      end
      vectors++;
      assert (loaded === got.loaded) else begin
        miscompares++;
        $error("FAIL %s loaded: observed %0b expected %0b", got.tag, loaded, got.loaded);
      end
      vectors++;
      assert (hold_cnt === got.cnt) else begin
        miscompares++;
        $error("FAIL %s hold_cnt: observed %0d expected %0d", got.tag, hold_cnt, got.cnt);
      end
    end
    $display("step %-10s rst_n=%0b i0=%0b i1=%0h i2=%0h -> y=%0h loaded=%0b hold_cnt=%0d",
             tag, rn, a0, a1, a2, y, loaded, hold_cnt);
  endtask

  initial begin
    int t;
    logic f0, f1, f2;
    vectors = 0; miscompares = 0;
    m_y = '0; m_loaded = 1'b0; m_cnt = '0;
    rst_n = 1'b0; i0 = 1'b1; i1 = 1'b1; i2 = 1'b0;

    // Reset overrides a load request
    step(1'b0, 1'b1, 1'b1, 1'b0, "reset");
    step(1'b0, 1'b1, 1'b1, 1'b0, "reset");

    // Hold of the reset value before any load
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b1, "preload");

    // Load then hold with i1 toggling
    step(1'b1, 1'b1, 1'b1, 1'b0, "load");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, WIDTH'(k[0]), 1'b0, "hold");

    // Saturation: 10 holds after a fresh load, then a load clears the counter
    step(1'b1, 1'b1, 1'b0, 1'b1, "load2");
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, WIDTH'(k[0]), "sat");
    step(1'b1, 1'b1, 1'b1, 1'b0, "satclr");
    step(1'b1, 1'b0, 1'b0, 1'b1, "hold3");

    // Reset asserted mid-sequence
    step(1'b0, 1'b0, 1'b1, 1'b1, "midreset");

    // Free-running toggles over 3000 ns with a 10 ns clock
    for (int k = 0; k < 300; k++) begin
      t  = k * 10;
      f0 = ((t / 317) % 2) == 1;
      f1 = ((t / 37) % 2) == 1;
      f2 = ((t / 57) % 2) == 1;
      step(1'b1, f0, WIDTH'(f1), WIDTH'(f2), "free");
    end

`ifdef COMPLETE_ELSE_EN
    step(1'b1, 1'b0, 1'b0, 1'b1, "else_i2");
    step(1'b1, 1'b1, 1'b0, 1'b1, "else_i1");
`endif

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain: observed %0d leftover entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
